// File: rtl/scc_pkg.sv
// Shared slot encodings, default widths and wave-bank mapping for the 5ch tone path.
package scc_pkg;

    localparam int SAMPLE_W_DEF = 8;
    localparam int VOL_W_DEF    = 4;
    localparam int NUM_CH       = 5;

    localparam logic [2:0] SLOT_A    = 3'd0;
    localparam logic [2:0] SLOT_B    = 3'd1;
    localparam logic [2:0] SLOT_C    = 3'd2;
    localparam logic [2:0] SLOT_D    = 3'd3;
    localparam logic [2:0] SLOT_E    = 3'd4;
    localparam logic [2:0] SLOT_IDLE = 3'd5;

    // Channel E borrows bank 3 unless the SCC-I layout gives it a private bank 4.
    function automatic logic [2:0] scc_wave_bank(input logic [2:0] ch, input logic scci_mode);
        logic [2:0] bank;
        bank = ch;
        if (ch == SLOT_E) begin
            bank = scci_mode ? 3'd4 : 3'd3;
        end
        return bank;
    endfunction

endpackage

// File: rtl/scc_volume_mac.sv
// Per-slot volume multiply, enable gate and frame accumulator; dumps the mix on channel E.
// One cycle from s2 tag to acc/mix update; no backpressure, a result is produced every valid slot.
module scc_volume_mac
    import scc_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int VOL_W    = VOL_W_DEF,
    parameter int MIX_W    = 15
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    s2_vld_i,
    input  logic [2:0]              s2_ch_i,
    input  logic [SAMPLE_W-1:0]     sample_i,
    input  logic [NUM_CH*VOL_W-1:0] reg_volume_i,
    input  logic [NUM_CH-1:0]       reg_enable_i,
    output logic [MIX_W-1:0]        mix_out_o,
    output logic                    mix_valid_o
);

    localparam int PROD_W = SAMPLE_W + VOL_W;

    logic [VOL_W-1:0]         vol_sel;
    logic                     en_sel;
    logic signed [PROD_W-1:0] samp_ext;
    logic signed [PROD_W-1:0] vol_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [MIX_W-1:0]  prod_ext;
    logic signed [MIX_W-1:0]  sum;
    logic signed [MIX_W-1:0]  acc_q, acc_d;
    logic [MIX_W-1:0]         mix_q, mix_d;
    logic                     mix_vld_q, mix_vld_d;

    always_comb begin
        vol_sel = '0;
        en_sel  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s2_ch_i == 3'(i)) begin
                vol_sel = reg_volume_i[i*VOL_W +: VOL_W];
                en_sel  = reg_enable_i[i];
            end
        end
    end

    // Volume is unsigned: widen with a zero MSB before the signed multiply.
    always_comb begin
        samp_ext = PROD_W'($signed(sample_i));
        vol_ext  = $signed(PROD_W'({1'b0, vol_sel}));
        prod     = en_sel ? (samp_ext * vol_ext) : '0;
        prod_ext = MIX_W'(prod);
        sum      = acc_q + prod_ext;
    end

    always_comb begin
        acc_d     = acc_q;
        mix_d     = mix_q;
        mix_vld_d = 1'b0;
        if (s2_vld_i) begin
            case (s2_ch_i)
                SLOT_A:                 acc_d = prod_ext;
                SLOT_B, SLOT_C, SLOT_D: acc_d = sum;
                SLOT_E: begin
                    mix_d     = sum;
                    mix_vld_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc_q     <= '0;
            mix_q     <= '0;
            mix_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mix_q     <= mix_d;
            mix_vld_q <= mix_vld_d;
        end
    end

    assign mix_out_o   = mix_q;
    assign mix_valid_o = mix_vld_q;

endmodule

// File: rtl/scc_wave_sample_reader_5ch.sv
// Reads wave RAM on slot updates, holds a sample per channel and mixes five channels per frame.
// Slot 4 -> mix_valid three cycles later; no backpressure, one slot accepted every cycle.
module scc_wave_sample_reader_5ch
    import scc_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int VOL_W    = VOL_W_DEF,
    parameter int MIX_W    = 15
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [2:0]              active,
    input  logic [4:0]              wave_address,
    input  logic                    wave_update,
    input  logic                    reg_scci_mode,
    input  logic [NUM_CH*VOL_W-1:0] reg_volume,
    input  logic [NUM_CH-1:0]       reg_enable,
    output logic [7:0]              ram_address,
    output logic                    ram_rd,
    input  logic [SAMPLE_W-1:0]     ram_rdata,
    output logic [MIX_W-1:0]        mix_out,
    output logic                    mix_valid
);

    logic                   slot_ok;
    logic [7:0]             ram_address_q, ram_address_d;
    logic                   ram_rd_q, ram_rd_d;
    logic [2:0]             s1_ch_q, s1_ch_d;
    logic                   s1_upd_q, s1_upd_d;
    logic                   s1_vld_q, s1_vld_d;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] sample_q, sample_d;
    logic [2:0]             s2_ch_q, s2_ch_d;
    logic                   s2_vld_q, s2_vld_d;
    logic [SAMPLE_W-1:0]    sample_sel;

    // S1: issue the RAM read and tag the slot; idle/ignored slots keep the last address.
    always_comb begin
        slot_ok       = (active < SLOT_IDLE);
        ram_address_d = ram_address_q;
        ram_rd_d      = 1'b0;
        s1_ch_d       = s1_ch_q;
        s1_upd_d      = 1'b0;
        s1_vld_d      = 1'b0;
        if (slot_ok) begin
            ram_address_d = {scc_wave_bank(active, reg_scci_mode), wave_address};
            ram_rd_d      = wave_update;
            s1_ch_d       = active;
            s1_upd_d      = wave_update;
            s1_vld_d      = 1'b1;
        end
    end

    // S2: capture read data into the tagged channel's holding register.
    always_comb begin
        sample_d = sample_q;
        if (s1_vld_q && s1_upd_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (s1_ch_q == 3'(i)) begin
                    sample_d[i] = ram_rdata;
                end
            end
        end
        s2_ch_d  = s1_ch_q;
        s2_vld_d = s1_vld_q;
    end

    always_comb begin
        sample_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s2_ch_q == 3'(i)) begin
                sample_sel = sample_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            ram_address_q <= '0;
            ram_rd_q      <= 1'b0;
            s1_ch_q       <= '0;
            s1_upd_q      <= 1'b0;
            s1_vld_q      <= 1'b0;
            sample_q      <= '0;
            s2_ch_q       <= '0;
            s2_vld_q      <= 1'b0;
        end else begin
            ram_address_q <= ram_address_d;
            ram_rd_q      <= ram_rd_d;
            s1_ch_q       <= s1_ch_d;
            s1_upd_q      <= s1_upd_d;
            s1_vld_q      <= s1_vld_d;
            sample_q      <= sample_d;
            s2_ch_q       <= s2_ch_d;
            s2_vld_q      <= s2_vld_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_rd      = ram_rd_q;

    scc_volume_mac #(
        .SAMPLE_W (SAMPLE_W),
        .VOL_W    (VOL_W),
        .MIX_W    (MIX_W)
    ) u_mac (
        .clk          (clk),
        .nreset       (nreset),
        .s2_vld_i     (s2_vld_q),
        .s2_ch_i      (s2_ch_q),
        .sample_i     (sample_sel),
        .reg_volume_i (reg_volume),
        .reg_enable_i (reg_enable),
        .mix_out_o    (mix_out),
        .mix_valid_o  (mix_valid)
    );

endmodule
